// File: rtl/hid_packet_parser.sv
// Frames the UART byte stream into HEADER/CMD/X/Y[/CHK] packets and emits cmd/x/y toward paint.
// Build with HID_CHECKSUM_EN defined to require a fifth byte, CHK == CMD ^ X ^ Y.
module hid_packet_parser #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         CMD_W          = 4,
  parameter int         COORD_W        = 6,
  parameter int         TIMEOUT_CYCLES = 1200000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [CMD_W-1:0]   cmd_to_screen,
  output logic [COORD_W-1:0] x_to_screen,
  output logic [COORD_W-1:0] y_to_screen,
  output logic               valid_pulse,
  output logic               frame_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef HID_CHECKSUM_EN
  localparam int SH_CMD_W = 8;
`else
  localparam int SH_CMD_W = CMD_W;
`endif

  typedef enum logic [2:0] {IDLE, GET_CMD, GET_X, GET_Y, GET_CHK, COMMIT} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [SH_CMD_W-1:0] r_cmd_sh;
  logic [7:0]          r_x_sh;
  logic [CMD_W-1:0]    r_cmd;
  logic [COORD_W-1:0]  r_x, r_y;
  logic                r_valid, r_ferr;
  logic                w_ld_cmd, w_ld_x, w_last, w_tout, w_ok;
  logic [7:0]          w_y_fin;

`ifdef HID_CHECKSUM_EN
  logic [7:0] r_y_sh;
  logic       w_ld_y;
  assign w_y_fin = r_y_sh;
  assign w_ok    = ((r_x_sh >> COORD_W) == 8'd0) && ((w_y_fin >> COORD_W) == 8'd0) &&
                   (rx_data == (r_cmd_sh ^ r_x_sh ^ r_y_sh));
`else
  // Without a checksum byte the Y byte itself closes the packet, so it is checked on the fly.
  assign w_y_fin = rx_data;
  assign w_ok    = ((r_x_sh >> COORD_W) == 8'd0) && ((w_y_fin >> COORD_W) == 8'd0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_ld_cmd    = 1'b0;
    w_ld_x      = 1'b0;
    w_last      = 1'b0;
    w_tout      = 1'b0;
`ifdef HID_CHECKSUM_EN
    w_ld_y      = 1'b0;
`endif
    case (r_state)
      IDLE, COMMIT: w_state_nxt = (rx_valid && rx_data == HEADER) ? GET_CMD : IDLE;
      GET_CMD: if (rx_valid) begin w_ld_cmd = 1'b1; w_state_nxt = GET_X; end
      GET_X:   if (rx_valid) begin w_ld_x = 1'b1; w_state_nxt = GET_Y; end
`ifdef HID_CHECKSUM_EN
      GET_Y:   if (rx_valid) begin w_ld_y = 1'b1; w_state_nxt = GET_CHK; end
      GET_CHK: if (rx_valid) begin w_last = 1'b1; w_state_nxt = COMMIT; end
`else
      GET_Y:   if (rx_valid) begin w_last = 1'b1; w_state_nxt = COMMIT; end
`endif
      default: w_state_nxt = IDLE;
    endcase
    // An arriving byte always beats the timeout in the same cycle.
    if (r_state inside {GET_CMD, GET_X, GET_Y, GET_CHK} && !rx_valid) begin
      if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        w_tout      = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_cmd_sh <= '0;
      r_x_sh   <= '0;
`ifdef HID_CHECKSUM_EN
      r_y_sh   <= '0;
`endif
      r_cmd    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_last && w_ok;
      r_ferr  <= (w_last && !w_ok) || w_tout;
      if (w_ld_cmd) r_cmd_sh <= rx_data[SH_CMD_W-1:0];
      if (w_ld_x)   r_x_sh   <= rx_data;
`ifdef HID_CHECKSUM_EN
      if (w_ld_y)   r_y_sh   <= rx_data;
`endif
      // Decision is registered on the last byte so the pulse lands in the COMMIT cycle.
      if (w_last && w_ok) begin
        r_cmd <= r_cmd_sh[CMD_W-1:0];
        r_x   <= r_x_sh[COORD_W-1:0];
        r_y   <= w_y_fin[COORD_W-1:0];
      end
    end
  end

  assign cmd_to_screen = r_cmd;
  assign x_to_screen   = r_x;
  assign y_to_screen   = r_y;
  assign valid_pulse   = r_valid;
  assign frame_error   = r_ferr;

endmodule

// File: tb/tb_hid_packet_parser.sv
// Random + directed byte streams against a packet-level reference model (byte queue per packet).
module tb_hid_packet_parser;

  localparam int T       = 40;
  localparam int CMD_W   = 4;
  localparam int COORD_W = 6;
`ifdef HID_CHECKSUM_EN
  localparam int PKT_LEN = 5;
`else
  localparam int PKT_LEN = 4;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_valid = 1'b0;
  logic [CMD_W-1:0]   cmd_to_screen;
  logic [COORD_W-1:0] x_to_screen, y_to_screen;
  logic               valid_pulse, frame_error;

  hid_packet_parser #(.HEADER(8'hA5), .CMD_W(CMD_W), .COORD_W(COORD_W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_to_screen(cmd_to_screen), .x_to_screen(x_to_screen), .y_to_screen(y_to_screen),
    .valid_pulse(valid_pulse), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: bytes of the packet being collected, idle cycles since the last one.
  logic [7:0] pkt[$];
  int         idle = 0;
  logic [7:0] m_cmd = 0, m_x = 0, m_y = 0;
  logic       exp_vp, exp_fe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("valid_pulse", 32'(valid_pulse), 32'(exp_vp));
    chk("frame_error", 32'(frame_error), 32'(exp_fe));
    chk("exclusive", 32'(valid_pulse & frame_error), 32'd0);
    chk("cmd", 32'(cmd_to_screen), 32'(m_cmd[CMD_W-1:0]));
    chk("x", 32'(x_to_screen), 32'(m_x));
    chk("y", 32'(y_to_screen), 32'(m_y));
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    bit ok;
    exp_vp = 1'b0;
    exp_fe = 1'b0;
    if (v) begin
      idle = 0;
      if (pkt.size() != 0 || d == 8'hA5) pkt.push_back(d);
      if (pkt.size() == PKT_LEN) begin
        ok = (pkt[2] < (1 << COORD_W)) && (pkt[3] < (1 << COORD_W));
`ifdef HID_CHECKSUM_EN
        ok = ok && (pkt[4] == (pkt[1] ^ pkt[2] ^ pkt[3]));
`endif
        if (ok) begin
          exp_vp = 1'b1;
          m_cmd = pkt[1];
          m_x = pkt[2];
          m_y = pkt[3];
        end else begin
          exp_fe = 1'b1;
        end
        pkt.delete();
      end
    end else if (pkt.size() != 0) begin
      idle++;
      if (idle == T) begin
        exp_fe = 1'b1;
        pkt.delete();
        idle = 0;
      end
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b);
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] x, input logic [7:0] y);
    send(8'hA5); send(c); send(x); send(y);
`ifdef HID_CHECKSUM_EN
    send(c ^ x ^ y);
`endif
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    pkt.delete();
    idle = 0;
    m_cmd = 0; m_x = 0; m_y = 0;
    exp_vp = 1'b0; exp_fe = 1'b0;
    #1 check_outputs();
    repeat (2) @(posedge clk);
    #1 check_outputs();
    rst = 1'b0;
  endtask

  task automatic rand_packet();
    logic [7:0] b[5];
    int kind, gap;
    kind = $urandom_range(0, 9);
    b[0] = 8'hA5;
    b[1] = 8'($urandom_range(0, 255));
    b[2] = 8'($urandom_range(0, 63));
    b[3] = 8'($urandom_range(0, 63));
    if (kind == 1) b[2] = 8'($urandom_range(0, 255));
    if (kind == 2) b[3] = 8'($urandom_range(0, 255));
    b[4] = b[1] ^ b[2] ^ b[3];
    if (kind == 3) b[4] = b[4] ^ 8'($urandom_range(1, 255));
    if (kind == 5) send(8'($urandom_range(0, 255)));
    for (int i = 0; i < PKT_LEN; i++) begin
      gap = (kind == 4 && i == 2) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 2);
      wait_idle(gap);
      send(b[i]);
    end
  endtask

  initial begin
    exp_vp = 1'b0;
    exp_fe = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs();
    rst = 1'b0;
    wait_idle(2);

    send_pkt(8'h03, 8'h10, 8'h20);
    wait_idle(2);
    send(8'h00); send(8'h7F);
    send_pkt(8'h01, 8'h05, 8'h06);
    send_pkt(8'h02, 8'h40, 8'h01);
    wait_idle(2);
    send(8'hA5); send(8'h02);
    wait_idle(T + 2);
    send_pkt(8'h04, 8'h01, 8'h02);
    // Byte arriving exactly on the timeout cycle must be accepted.
    send(8'hA5); wait_idle(T - 1); send(8'h06); wait_idle(T - 1); send(8'h07);
    send(8'h08);
`ifdef HID_CHECKSUM_EN
    send(8'h09);
`endif
    // HEADER value inside a packet is plain data.
    send_pkt(8'hA5, 8'h0A, 8'h0B);
`ifdef HID_CHECKSUM_EN
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'hFF);
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h00);
`endif
    send(8'hA5); send(8'h01); send(8'h02);
    do_reset();
    wait_idle(1);
    send_pkt(8'h05, 8'h09, 8'h0A);
    wait_idle(2);

    for (int i = 0; i < 300; i++) rand_packet();
    wait_idle(T + 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
